// File: rtl/cdc_event_arb_pkg.sv
// Package for the cross-domain event arbiter.
//   cdc_event_arb_state_t : handshake FSM state encoding
//   DEF_NUM_REQ           : default requester count
//   DEF_TIMEOUT_CYCLES    : default watchdog limit
package cdc_event_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } cdc_event_arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/cdc_event_arbiter_rr_pick.sv
// rr_priority_pick: combinational round-robin selector.
//   req    : request vector
//   last   : id of the most recently granted requester
//   any    : at least one request is set
//   winner : first set request at or after last+1, wrapping modulo NUM_REQ
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest
    // set request is the last one written and therefore wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/cdc_event_arbiter.sv
// cdc_event_arbiter: latches per-requester event pulses and serializes them
// round-robin onto one four-phase req/ack channel toward another clock domain.
//   clk, reset     : sole clock, synchronous active-high reset
//   req_pulse      : one-cycle event pulse per requester
//   pending        : latched events not yet granted
//   xfer_req       : registered level request to the far domain
//   xfer_id        : registered id of the granted requester
//   xfer_ack_sync  : far-side acknowledge, already synchronized into clk
//   done_pulse     : one-cycle completion strobe per requester
//   timeout_err    : sticky watchdog error
// Optional feature macro: CDC_EVENT_ARB_TIMEOUT_EN builds the REQ/RELEASE
// watchdog; without it the handshake waits forever and timeout_err is 0.
module cdc_event_arbiter
    import cdc_event_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_pulse,
    output logic [NUM_REQ-1:0] pending,
    output logic               xfer_req,
    output logic [ID_W-1:0]    xfer_id,
    input  logic               xfer_ack_sync,
    output logic [NUM_REQ-1:0] done_pulse,
    output logic               timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cdc_event_arbiter: parameter out of range");
    end

    cdc_event_arb_state_t state, next_state;
    logic [ID_W-1:0]      last_grant;
    logic                 any;
    logic [ID_W-1:0]      winner;
    logic                 launch;
    logic [NUM_REQ-1:0]   grant_clr;
    logic                 xfer_req_d;
    logic [NUM_REQ-1:0]   done_d;
    logic                 tmo;
    logic                 tmo_fire;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (pending),
        .last   (last_grant),
        .any    (any),
        .winner (winner)
    );

    // A timeout only matters when the normal exit condition is absent,
    // so an ack arriving on the limit cycle still completes normally.
    assign tmo_fire = tmo && (((state == REQ) && !xfer_ack_sync) ||
                              ((state == RELEASE) && xfer_ack_sync));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any && !xfer_ack_sync) next_state = SETUP;
            SETUP:   next_state = REQ;
            REQ:     if (xfer_ack_sync)   next_state = RELEASE;
                     else if (tmo_fire)   next_state = IDLE;
            RELEASE: if (!xfer_ack_sync)  next_state = IDLE;
                     else if (tmo_fire)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        launch     = (state == IDLE) && (next_state == SETUP);
        grant_clr  = launch ? (NUM_REQ'(1) << winner) : '0;
        xfer_req_d = (next_state == REQ);
        done_d     = ((state == REQ) && xfer_ack_sync) ? (NUM_REQ'(1) << xfer_id) : '0;
    end

    // Registered outputs and pending latch; a new pulse beats the grant
    // clear of the same bit so the second event is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            xfer_req   <= 1'b0;
            xfer_id    <= '0;
            done_pulse <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            pending    <= (pending & ~grant_clr) | req_pulse;
            xfer_req   <= xfer_req_d;
            done_pulse <= done_d;
            if (launch) begin
                xfer_id    <= winner;
                last_grant <= winner;
            end
        end
    end

`ifdef CDC_EVENT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             err_q;

    // wd_cnt holds the number of cycles spent in the current REQ/RELEASE
    // state, counting the present one; it saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (next_state != state)
                wd_cnt <= CNT_W'(1);
            else if ((state == REQ || state == RELEASE) &&
                     (wd_cnt != CNT_W'(TIMEOUT_CYCLES)))
                wd_cnt <= wd_cnt + CNT_W'(1);
            if (tmo_fire)
                err_q <= 1'b1;
        end
    end

    assign tmo = (state == REQ || state == RELEASE) &&
                 (wd_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_err = err_q;
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Directed bench for cdc_event_arbiter with a grant scoreboard: expected
// requester ids are queued as stimulus is applied and checked whenever a
// done_pulse appears.
module tb_cdc_event_arbiter;
    import cdc_event_arb_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_pulse = '0;
    logic [NR-1:0] pending;
    logic          xfer_req;
    logic [IW-1:0] xfer_id;
    logic          xfer_ack_sync = 1'b0;
    logic [NR-1:0] done_pulse;
    logic          timeout_err;

    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_q[$];

    cdc_event_arbiter #(
        .NUM_REQ        (NR),
        .ID_W           (IW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_pulse     (req_pulse),
        .pending       (pending),
        .xfer_req      (xfer_req),
        .xfer_id       (xfer_id),
        .xfer_ack_sync (xfer_ack_sync),
        .done_pulse    (done_pulse),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Far-side responder: either mirrors xfer_req (auto) or a manual level.
    always @(posedge clk) begin
        #2;
        xfer_ack_sync = auto_ack ? xfer_req : man_ack;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int cyc;
        cyc = 0;
        while (done_cnt < target && cyc < budget) begin
            step();
            cyc++;
        end
        chk(tag, 32'(done_cnt), 32'(target));
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset && done_pulse !== '0) begin
            int e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'(done_pulse), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_onehot", 32'(done_pulse), 32'(1) << e);
                chk("done_xfer_id", 32'(xfer_id), 32'(e));
            end
        end
    end

    initial begin
        int base;
        int cyc;

        // ---- reset
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_xfer_req", 32'(xfer_req), 32'(0));
        chk("rst_xfer_id", 32'(xfer_id), 32'(0));
        chk("rst_done", 32'(done_pulse), 32'(0));
        chk("rst_timeout", 32'(timeout_err), 32'(0));
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // ---- simultaneous requests: round-robin from 0 after reset
        auto_ack = 1'b1;
        base = done_cnt;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        step();
        req_pulse = 4'b1011;
        step();
        req_pulse = '0;
        wait_done("simul_wait", base + 3, 100);
        repeat (10) step();
        chk("simul_count", 32'(done_cnt), 32'(base + 3));
        chk("simul_pending", 32'(pending), 32'(0));

        // ---- fairness: 0 and 3 pulse every cycle, grants must alternate
        base = done_cnt;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(0);
            exp_q.push_back(3);
        end
        cyc = 0;
        while (done_cnt < base + 4 && cyc < 200) begin
            req_pulse = 4'b1001;
            step();
            cyc++;
        end
        req_pulse = '0;
        chk("fair_wait", 32'(done_cnt >= base + 4), 32'(1));
        cyc = 0;
        while (!(pending == '0 && dut.state == IDLE && !xfer_ack_sync) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("fair_drain", 32'(pending), 32'(0));
        exp_q.delete();
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        repeat (3) step();

        // ---- single event on requester 2, manual ack 5 cycles after req
        req_pulse = 4'b0100;
        exp_q.push_back(2);
        step();                       // cycle 1
        req_pulse = '0;
        @(negedge clk);
        chk("single_pend_c1", 32'(pending), 32'h4);
        chk("single_req_c1", 32'(xfer_req), 32'(0));
        step();                       // cycle 2
        @(negedge clk);
        chk("single_id_c2", 32'(xfer_id), 32'(2));
        chk("single_pend_c2", 32'(pending), 32'(0));
        chk("single_req_c2", 32'(xfer_req), 32'(0));
        chk("single_state_c2", 32'(dut.state), 32'(SETUP));
        step();                       // cycle 3
        @(negedge clk);
        chk("single_req_c3", 32'(xfer_req), 32'(1));
        repeat (5) step();            // cycle 8: ack rises
        man_ack = 1'b1;
        @(negedge clk);
        chk("single_req_c8", 32'(xfer_req), 32'(1));
        chk("single_nodone_c8", 32'(done_pulse), 32'(0));
        step();                       // cycle 9: ack falls
        man_ack = 1'b0;
        @(negedge clk);
        chk("single_done_c9", 32'(done_pulse), 32'h4);
        chk("single_req_c9", 32'(xfer_req), 32'(0));
        chk("single_state_c9", 32'(dut.state), 32'(RELEASE));
        step();                       // cycle 10
        @(negedge clk);
        chk("single_idle_c10", 32'(dut.state), 32'(IDLE));
        chk("single_nodone_c10", 32'(done_pulse), 32'(0));

        // ---- coalesce: ack held high blocks launch while pulses pile up
        man_ack = 1'b1;
        step(); step();
        base = done_cnt;
        for (int i = 0; i < 3; i++) begin
            req_pulse = 4'b0010;
            step();
            req_pulse = '0;
            step();
        end
        @(negedge clk);
        chk("coal_pending", 32'(pending), 32'h2);
        chk("coal_blocked", 32'(dut.state), 32'(IDLE));
        exp_q.push_back(1);
        man_ack  = 1'b0;
        auto_ack = 1'b1;
        wait_done("coal_wait", base + 1, 50);
        repeat (10) step();
        chk("coal_one_xfer", 32'(done_cnt), 32'(base + 1));
        auto_ack = 1'b0;
        repeat (2) step();

        // ---- set wins over grant clear
        base = done_cnt;
        req_pulse = 4'b0010;
        step();                       // cycle 1: launch cycle
        req_pulse = 4'b0010;
        step();                       // cycle 2
        req_pulse = '0;
        @(negedge clk);
        chk("setwin_pending", 32'(pending), 32'h2);
        chk("setwin_id", 32'(xfer_id), 32'(1));
        exp_q.push_back(1); exp_q.push_back(1);
        auto_ack = 1'b1;
        wait_done("setwin_wait", base + 2, 60);
        auto_ack = 1'b0;
        repeat (3) step();

        // ---- reset during REQ, then stuck ack after reset
        req_pulse = 4'b0100;
        step();
        req_pulse = '0;
        step();
        req_pulse = 4'b1000;          // lands in pending[3] before reset
        step();
        req_pulse = '0;
        @(negedge clk);
        chk("rreq_active", 32'(xfer_req), 32'(1));
        chk("rreq_pend3", 32'(pending), 32'h8);
        reset   = 1'b1;
        man_ack = 1'b1;
        step();
        @(negedge clk);
        chk("rreq_xfer_req", 32'(xfer_req), 32'(0));
        chk("rreq_pending", 32'(pending), 32'(0));
        chk("rreq_xfer_id", 32'(xfer_id), 32'(0));
        chk("rreq_done", 32'(done_pulse), 32'(0));
        chk("rreq_state", 32'(dut.state), 32'(IDLE));
        step();
        reset = 1'b0;
        base = done_cnt;
        req_pulse = 4'b0011;
        step();
        req_pulse = '0;
        repeat (5) step();
        @(negedge clk);
        chk("stuck_state", 32'(dut.state), 32'(IDLE));
        chk("stuck_req", 32'(xfer_req), 32'(0));
        chk("stuck_pending", 32'(pending), 32'h3);
        exp_q.push_back(0); exp_q.push_back(1);
        man_ack  = 1'b0;
        auto_ack = 1'b1;
        wait_done("stuck_wait", base + 2, 60);
        auto_ack = 1'b0;
        repeat (3) step();

`ifdef CDC_EVENT_ARB_TIMEOUT_EN
        // ---- watchdog: last grant is 1, so 2 goes first and times out
        base = done_cnt;
        req_pulse = 4'b0110;
        step();                       // cycle 1
        req_pulse = '0;
        step();                       // cycle 2
        @(negedge clk);
        chk("wd_id", 32'(xfer_id), 32'(2));
        step();                       // cycle 3
        @(negedge clk);
        chk("wd_req_c3", 32'(xfer_req), 32'(1));
        repeat (15) step();           // cycle 18: 16th REQ cycle
        @(negedge clk);
        chk("wd_req_c18", 32'(xfer_req), 32'(1));
        chk("wd_err_c18", 32'(timeout_err), 32'(0));
        step();                       // cycle 19
        @(negedge clk);
        chk("wd_req_c19", 32'(xfer_req), 32'(0));
        chk("wd_err_c19", 32'(timeout_err), 32'(1));
        chk("wd_nodone", 32'(done_pulse), 32'(0));
        chk("wd_state", 32'(dut.state), 32'(IDLE));
        exp_q.push_back(1);
        auto_ack = 1'b1;
        wait_done("wd_next_wait", base + 1, 60);
        chk("wd_err_sticky", 32'(timeout_err), 32'(1));
        auto_ack = 1'b0;
        repeat (3) step();
`else
        chk("no_wd_err", 32'(timeout_err), 32'(0));
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_event_arbiter.md
# cdc_event_arbiter

Source-domain scheduler that shares one cross-domain event channel between several requesters. Each requester raises one-clock event pulses; the block latches them and serializes them round-robin onto a single four-phase req/ack handshake. That handshake carries a channel id to the far clock domain through the two-flop synchronizers. The block runs entirely in `clk`; the returning acknowledge arrives already synchronized into `clk`.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the channel id.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Only used when the timeout feature is compiled in.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `req_pulse`  in  NUM_REQ  one-cycle event pulse per requester.
- `pending`  out  NUM_REQ  latched, not-yet-granted events.
- `xfer_req`  out  1  level request toward the far domain. Registered.
- `xfer_id`  out  ID_W  id of the granted requester. Registered.
- `xfer_ack_sync`  in  1  far-side acknowledge, already two-flop synchronized into `clk`.
- `done_pulse`  out  NUM_REQ  one-cycle completion strobe per requester.
- `timeout_err`  out  1  sticky watchdog error.

## Operation
- **Pending latch.**
  - `pending[i]` sets the cycle after `req_pulse[i]`.
  - Further pulses while it is set coalesce into one event.
  - It clears when requester i is granted.
  - If a pulse and the grant-clear for the same bit happen in the same cycle, set wins and the new event stays pending.
- **States.**
  - IDLE: if any `pending` bit is set and `xfer_ack_sync`=0, go to SETUP. Latch `xfer_id` = round-robin winner and clear its pending bit.
  - SETUP: one cycle with `xfer_id` stable and `xfer_req`=0. Always go to REQ.
  - REQ: `xfer_req`=1. When `xfer_ack_sync`=1, go to RELEASE and pulse `done_pulse[xfer_id]` for one cycle.
  - RELEASE: `xfer_req`=0. When `xfer_ack_sync`=0, go to IDLE.
- **Round-robin.**
  - The search starts at last-granted+1 and wraps modulo NUM_REQ.
  - After reset the last-granted pointer is NUM_REQ-1, so requester 0 has first priority.
- `xfer_id` holds its value outside SETUP and REQ; it changes only on the IDLE→SETUP transition.
- An ack that is still high after reset blocks launch: IDLE waits until `xfer_ack_sync` is 0.

## Timing
- Reset values:
  - state = IDLE
  - `pending` = 0
  - `xfer_req` = 0
  - `xfer_id` = 0
  - `done_pulse` = 0
  - `timeout_err` = 0
  - last-grant pointer = NUM_REQ-1
- Cycle-level latency, with `req_pulse` at cycle 0 and the block idle:
  - `pending` is set at cycle 1.
  - SETUP and `xfer_id` valid at cycle 2; `pending` cleared.
  - `xfer_req`=1 at cycle 3.
- If ack rises at cycle n: `xfer_req`=0 and `done_pulse` at n+1.
- If ack falls at cycle m: IDLE at m+1, with the next SETUP possible at m+2.
- Minimum spacing between back-to-back grants is therefore 4 cycles plus the ack round trip.
- Reset mid-transfer:
  - All state is cleared.
  - The in-flight event is dropped with no `done_pulse`.
  - Its pending bit is not restored.

## Configuration
- `CDC_EVENT_ARB_TIMEOUT_EN` defined:
  - A counter runs in REQ and RELEASE and restarts on each state entry.
  - Reaching TIMEOUT_CYCLES in either state:
    - drop `xfer_req`;
    - set `timeout_err` (cleared only by reset);
    - go to IDLE without `done_pulse`.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
- Not defined:
  - No counter is built.
  - The handshake waits indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Package `cdc_event_arb_pkg` holds:
  - the state enum `cdc_event_arb_state_t` (IDLE, SETUP, REQ, RELEASE);
  - the default-parameter localparams.
- Sub-module `rr_priority_pick`: purely combinational.
  - Inputs: request vector and last-grant pointer.
  - Outputs: `any` and `winner` id.
  - It is reusable by other arbiters in the design.
- The top level holds:
  - the pending latch;
  - the FSM;
  - the registered outputs;
  - the optional watchdog.

## Test plan
- **Single event:** `req_pulse[2]` at cycle 0, ack returned 5 cycles after `xfer_req` rises.
  - Expect: `xfer_id`=2 at cycle 2, `xfer_req` high from cycle 3.
  - Expect: `done_pulse[2]` one cycle after ack rises; IDLE one cycle after ack falls.
- **Simultaneous requests:** `req_pulse`=4'b1011 in one cycle, auto-ack responder.
  - Expect grant order 0, 1, 3.
  - Expect exactly three `done_pulse` strobes.
  - Expect `pending`=0 at end.
- **Coalesce and set-wins:**
  - Three pulses on requester 1 while it is pending → one transfer.
  - A pulse landing in the grant-clear cycle → a second transfer follows.
- **Fairness:** requesters 0 and 3 pulsing continuously.
  - Expect alternating grants 0, 3, 0, 3.
  - Neither may be granted twice in a row.
- **Reset mid-REQ and stuck ack:**
  - Reset while `xfer_req`=1 → all outputs 0 next cycle.
  - Hold ack=1 after reset with requests pending → no SETUP until ack drops.
- **Watchdog** (`CDC_EVENT_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=16): no ack.
  - Expect `xfer_req` dropped and `timeout_err`=1 after 16 REQ cycles.
  - Expect no `done_pulse`; the next pending requester is served afterwards.
